// File: rtl/ps2_pkg.sv
// Shared types and constants for the PS/2 scancode receiver.
package ps2_pkg;

    localparam int unsigned EVENT_W    = 10;
    localparam int unsigned CODE_W     = 8;
    localparam int unsigned FRAME_BITS = 11;
    localparam int unsigned BIT_CNT_W  = 4;

    localparam logic [CODE_W-1:0] E0 = 8'hE0;
    localparam logic [CODE_W-1:0] F0 = 8'hF0;

    // Serial frame receiver states
    typedef enum logic [1:0] {
        F_IDLE  = 2'd0,
        F_SHIFT = 2'd1,
        F_CHECK = 2'd2
    } frame_state_t;

    // Scancode prefix decoder states
    typedef enum logic [1:0] {
        D_BASE    = 2'd0,
        D_EXT     = 2'd1,
        D_BRK     = 2'd2,
        D_EXT_BRK = 2'd3
    } dec_state_t;

    // Key event as seen by the consumer: {ext, brk, code}
    typedef struct packed {
        logic              ext;
        logic              brk;
        logic [CODE_W-1:0] code;
    } ps2_event_t;

    // Start low, stop high, odd parity over data plus parity bit
    function automatic logic frame_ok(input logic [FRAME_BITS-1:0] f);
        return (f[0] == 1'b0) && (f[10] == 1'b1) && (^f[9:1] == 1'b1);
    endfunction

endpackage

// File: rtl/ps2_scancode_rx_if.sv
// Event stream handshake between the receiver and its consumer.
interface ps2_scancode_rx_if;
    import ps2_pkg::*;

    logic [EVENT_W-1:0] out_data;
    logic               out_valid;
    logic               out_ready;

    modport master (
        output out_data,
        output out_valid,
        input  out_ready
    );

    modport slave (
        input  out_data,
        input  out_valid,
        output out_ready
    );

endinterface

// File: rtl/ps2_event_fifo.sv
// First-word-fall-through event FIFO with wrap-bit full/empty detection.
module ps2_event_fifo #(
    parameter int unsigned DEPTH = 8,
    parameter int unsigned WIDTH = 10
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             push_i,
    input  logic [WIDTH-1:0] push_data_i,
    input  logic             pop_i,
    output logic [WIDTH-1:0] head_o,
    output logic             valid_o,
    output logic             full_o
);

    localparam int unsigned AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    logic [AW:0]      wr_q, wr_d;
    logic [AW:0]      rd_q, rd_d;
    logic [WIDTH-1:0] mem_q [DEPTH];
    logic             empty_c;
    logic             do_pop_c;
    logic             do_push_c;

    // Status flags and accepted push/pop for this cycle
    always_comb begin
        empty_c   = (wr_q == rd_q);
        full_o    = (wr_q[AW] != rd_q[AW]) && (wr_q[AW-1:0] == rd_q[AW-1:0]);
        do_pop_c  = pop_i && !empty_c;
        do_push_c = push_i && (!full_o || do_pop_c);
        wr_d      = do_push_c ? wr_q + (AW+1)'(1) : wr_q;
        rd_d      = do_pop_c  ? rd_q + (AW+1)'(1) : rd_q;
    end

    // Pointer registers
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            wr_q <= '0;
            rd_q <= '0;
        end else begin
            wr_q <= wr_d;
            rd_q <= rd_d;
        end
    end

    // Storage; contents are don't-care until written
    always_ff @(posedge clk) begin
        if (do_push_c) begin
            mem_q[wr_q[AW-1:0]] <= push_data_i;
        end
    end

    assign valid_o = !empty_c;
    assign head_o  = empty_c ? '0 : mem_q[rd_q[AW-1:0]];

endmodule

// File: rtl/ps2_scancode_rx.sv
// PS/2 keyboard receiver: synchronise, deframe, decode E0/F0 prefixes, queue events.
module ps2_scancode_rx
    import ps2_pkg::*;
#(
    parameter int unsigned FIFO_DEPTH     = 8,
    parameter int unsigned SYNC_STAGES    = 3,
    parameter int unsigned TIMEOUT_CYCLES = 50000
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              ps2_clk,
    input  logic              ps2_data,
    ps2_scancode_rx_if.master evt,
    output logic              overflow,
    output logic              frame_err,
    input  logic              clr_err
);

    localparam int unsigned TO_W = $clog2(TIMEOUT_CYCLES + 1);

    logic [SYNC_STAGES-1:0] clk_sync_q, clk_sync_d;
    logic [SYNC_STAGES-1:0] data_sync_q, data_sync_d;
    logic                   clk_prev_q, clk_prev_d;

    frame_state_t           fstate_q, fstate_d;
    dec_state_t             dstate_q, dstate_d;
    logic [FRAME_BITS-1:0]  frame_q, frame_d;
    logic [BIT_CNT_W-1:0]   bit_cnt_q, bit_cnt_d;
    logic [TO_W-1:0]        to_cnt_q, to_cnt_d;
    logic                   overflow_q, overflow_d;
    logic                   frame_err_q, frame_err_d;

    logic                   clk_s_c;
    logic                   data_s_c;
    logic                   edge_c;
    logic [CODE_W-1:0]      byte_c;
    logic                   err_set_c;
    logic                   push_c;
    ps2_event_t             evt_c;
    logic                   pop_c;
    logic                   full_c;

    // Synchroniser shift and falling-edge detect on the synced PS/2 clock
    always_comb begin
        clk_sync_d  = {clk_sync_q[SYNC_STAGES-2:0], ps2_clk};
        data_sync_d = {data_sync_q[SYNC_STAGES-2:0], ps2_data};
        clk_s_c     = clk_sync_q[SYNC_STAGES-1];
        data_s_c    = data_sync_q[SYNC_STAGES-1];
        clk_prev_d  = clk_s_c;
        edge_c      = clk_prev_q && !clk_s_c;
    end

    assign byte_c = frame_q[8:1];
    assign pop_c  = evt.out_valid && evt.out_ready;

    // Frame FSM, prefix decoder and sticky error flags: next-state logic
    always_comb begin
        fstate_d  = fstate_q;
        dstate_d  = dstate_q;
        frame_d   = frame_q;
        bit_cnt_d = bit_cnt_q;
        to_cnt_d  = to_cnt_q;
        err_set_c = 1'b0;
        push_c    = 1'b0;
        evt_c     = '0;

        case (fstate_q)
            F_IDLE: begin
                to_cnt_d  = '0;
                bit_cnt_d = '0;
                if (edge_c) begin
                    frame_d    = '0;
                    frame_d[0] = data_s_c;
                    bit_cnt_d  = BIT_CNT_W'(1);
                    fstate_d   = F_SHIFT;
                end
            end

            F_SHIFT: begin
                if (edge_c) begin
                    frame_d[bit_cnt_q] = data_s_c;
                    to_cnt_d           = '0;
                    bit_cnt_d          = bit_cnt_q + BIT_CNT_W'(1);
                    if (bit_cnt_q == BIT_CNT_W'(FRAME_BITS - 1)) begin
                        fstate_d = F_CHECK;
                    end
                end else if (to_cnt_q == TO_W'(TIMEOUT_CYCLES - 1)) begin
                    // Stalled device: drop the partial frame
                    fstate_d  = F_IDLE;
                    to_cnt_d  = '0;
                    bit_cnt_d = '0;
                    err_set_c = 1'b1;
                end else begin
                    to_cnt_d = to_cnt_q + TO_W'(1);
                end
            end

            F_CHECK: begin
                fstate_d  = F_IDLE;
                bit_cnt_d = '0;
                to_cnt_d  = '0;
                if (frame_ok(frame_q)) begin
                    if (byte_c == F0) begin
                        case (dstate_q)
                            D_EXT, D_EXT_BRK: dstate_d = D_EXT_BRK;
                            default:          dstate_d = D_BRK;
                        endcase
                    end else if ((byte_c == E0) &&
                                 ((dstate_q == D_BASE) || (dstate_q == D_EXT))) begin
                        dstate_d = D_EXT;
                    end else begin
                        // Code byte; an E0 after a break prefix lands here too
                        push_c     = 1'b1;
                        evt_c.ext  = (dstate_q == D_EXT) || (dstate_q == D_EXT_BRK);
                        evt_c.brk  = (dstate_q == D_BRK) || (dstate_q == D_EXT_BRK);
                        evt_c.code = byte_c;
                        dstate_d   = D_BASE;
                    end
                end else begin
                    err_set_c = 1'b1;
                end
            end

            default: begin
                fstate_d = F_IDLE;
            end
        endcase

        overflow_d  = (overflow_q && !clr_err) || (push_c && full_c && !pop_c);
        frame_err_d = (frame_err_q && !clr_err) || err_set_c;
    end

    // State registers; synchronisers idle high so reset release is edge-free
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            clk_sync_q  <= '1;
            data_sync_q <= '1;
            clk_prev_q  <= 1'b1;
            fstate_q    <= F_IDLE;
            dstate_q    <= D_BASE;
            frame_q     <= '0;
            bit_cnt_q   <= '0;
            to_cnt_q    <= '0;
            overflow_q  <= 1'b0;
            frame_err_q <= 1'b0;
        end else begin
            clk_sync_q  <= clk_sync_d;
            data_sync_q <= data_sync_d;
            clk_prev_q  <= clk_prev_d;
            fstate_q    <= fstate_d;
            dstate_q    <= dstate_d;
            frame_q     <= frame_d;
            bit_cnt_q   <= bit_cnt_d;
            to_cnt_q    <= to_cnt_d;
            overflow_q  <= overflow_d;
            frame_err_q <= frame_err_d;
        end
    end

    assign overflow  = overflow_q;
    assign frame_err = frame_err_q;

    // Event queue towards the consumer
    ps2_event_fifo #(
        .DEPTH (FIFO_DEPTH),
        .WIDTH (EVENT_W)
    ) u_fifo (
        .clk         (clk),
        .reset       (reset),
        .push_i      (push_c),
        .push_data_i (EVENT_W'(evt_c)),
        .pop_i       (evt.out_ready),
        .head_o      (evt.out_data),
        .valid_o     (evt.out_valid),
        .full_o      (full_c)
    );

endmodule

// File: tb/tb_ps2_scancode_rx.sv
// Self-checking bench for ps2_scancode_rx.
module tb_ps2_scancode_rx;

    localparam int unsigned DEPTH   = 4;
    localparam int unsigned SYNC    = 3;
    localparam int unsigned TIMEOUT = 300;

    logic clk      = 1'b0;
    logic reset    = 1'b0;
    logic ps2_clk  = 1'b1;
    logic ps2_data = 1'b1;
    logic clr_err  = 1'b0;
    logic overflow;
    logic frame_err;

    int n_tests = 0;
    int n_fail  = 0;

    ps2_scancode_rx_if bus ();

    ps2_scancode_rx #(
        .FIFO_DEPTH     (DEPTH),
        .SYNC_STAGES    (SYNC),
        .TIMEOUT_CYCLES (TIMEOUT)
    ) dut (
        .clk       (clk),
        .reset     (reset),
        .ps2_clk   (ps2_clk),
        .ps2_data  (ps2_data),
        .evt       (bus),
        .overflow  (overflow),
        .frame_err (frame_err),
        .clr_err   (clr_err)
    );

    always #5 clk = ~clk;

    // Reference decoder: prefix flags and an event queue
    bit          m_ext = 1'b0;
    bit          m_brk = 1'b0;
    logic [9:0]  mq[$];

    function automatic void model_byte(input logic [7:0] b);
        if (b == 8'hF0) begin
            m_brk = 1'b1;
        end else if (b == 8'hE0 && !m_brk) begin
            m_ext = 1'b1;
        end else begin
            mq.push_back({m_ext, m_brk, b});
            m_ext = 1'b0;
            m_brk = 1'b0;
        end
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic cyc(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic send_bit(input logic b);
        ps2_data = b;
        cyc(8);
        ps2_clk = 1'b0;
        cyc(8);
        ps2_clk = 1'b1;
    endtask

    task automatic send_frame(input logic [7:0] b, input bit bad);
        logic p;
        p = ~^b;
        if (bad) p = ~p;
        send_bit(1'b0);
        for (int i = 0; i < 8; i++) send_bit(b[i]);
        send_bit(p);
        send_bit(1'b1);
        cyc(4);
    endtask

    task automatic pop_one();
        bus.out_ready = 1'b1;
        cyc(1);
        bus.out_ready = 1'b0;
    endtask

    task automatic clr_pulse();
        clr_err = 1'b1;
        cyc(1);
        clr_err = 1'b0;
    endtask

    typedef struct {
        logic [7:0] code;
        bit         bad;
        bit         exp_v;
        logic [9:0] exp_d;
        bit         exp_err;
    } vec_t;

    vec_t tbl[13];

    initial begin
        logic [7:0] b;
        logic [9:0] e;
        logic [7:0] code5a;
        bit         bad;

        tbl[0]  = '{8'h1C, 1'b0, 1'b1, 10'h01C, 1'b0};
        tbl[1]  = '{8'hE0, 1'b0, 1'b0, 10'h000, 1'b0};
        tbl[2]  = '{8'hF0, 1'b0, 1'b0, 10'h000, 1'b0};
        tbl[3]  = '{8'h75, 1'b0, 1'b1, 10'h375, 1'b0};
        tbl[4]  = '{8'h75, 1'b0, 1'b1, 10'h075, 1'b0};
        tbl[5]  = '{8'h1C, 1'b1, 1'b0, 10'h000, 1'b1};
        tbl[6]  = '{8'hF0, 1'b0, 1'b0, 10'h000, 1'b0};
        tbl[7]  = '{8'hE0, 1'b0, 1'b1, 10'h1E0, 1'b0};
        tbl[8]  = '{8'hE0, 1'b0, 1'b0, 10'h000, 1'b0};
        tbl[9]  = '{8'hE0, 1'b0, 1'b0, 10'h000, 1'b0};
        tbl[10] = '{8'hF0, 1'b0, 1'b0, 10'h000, 1'b0};
        tbl[11] = '{8'hF0, 1'b0, 1'b0, 10'h000, 1'b0};
        tbl[12] = '{8'h6B, 1'b0, 1'b1, 10'h36B, 1'b0};

        bus.out_ready = 1'b0;
        cyc(3);
        check("rst_valid", 32'(bus.out_valid), 32'd0);
        check("rst_data", 32'(bus.out_data), 32'd0);
        check("rst_ovf", 32'(overflow), 32'd0);
        check("rst_ferr", 32'(frame_err), 32'd0);
        reset = 1'b1;
        cyc(4);

        // Latency from the stop-bit falling edge to out_valid
        b = 8'h1C;
        send_bit(1'b0);
        for (int i = 0; i < 8; i++) send_bit(b[i]);
        send_bit(~^b);
        ps2_data = 1'b1;
        cyc(8);
        ps2_clk = 1'b0;
        for (int k = 1; k <= int'(SYNC) + 2; k++) begin
            @(posedge clk);
            @(negedge clk);
            if (k == int'(SYNC) + 1) check("lat_early", 32'(bus.out_valid), 32'd0);
            if (k == int'(SYNC) + 2) begin
                check("lat_valid", 32'(bus.out_valid), 32'd1);
                check("lat_data", 32'(bus.out_data), 32'h01C);
            end
        end
        cyc(4);
        ps2_clk = 1'b1;
        check("lat_hold", 32'(bus.out_data), 32'h01C);
        pop_one();
        check("lat_empty", 32'(bus.out_valid), 32'd0);

        // Table of byte sequences
        for (int i = 0; i < 13; i++) begin
            send_frame(tbl[i].code, tbl[i].bad);
            check($sformatf("tbl%0d_valid", i), 32'(bus.out_valid), 32'(tbl[i].exp_v));
            if (tbl[i].exp_v) check($sformatf("tbl%0d_data", i), 32'(bus.out_data), 32'(tbl[i].exp_d));
            check($sformatf("tbl%0d_ferr", i), 32'(frame_err), 32'(tbl[i].exp_err));
            if (tbl[i].exp_v) pop_one();
            if (tbl[i].exp_err) begin
                clr_pulse();
                check($sformatf("tbl%0d_clr", i), 32'(frame_err), 32'd0);
            end
        end

        // Timeout on a stalled partial frame
        send_bit(1'b0);
        send_bit(1'b1);
        send_bit(1'b0);
        send_bit(1'b1);
        cyc(int'(TIMEOUT) - 20);
        check("to_before", 32'(frame_err), 32'd0);
        cyc(40);
        check("to_ferr", 32'(frame_err), 32'd1);
        check("to_valid", 32'(bus.out_valid), 32'd0);
        clr_pulse();
        check("to_clr", 32'(frame_err), 32'd0);
        send_frame(8'h29, 1'b0);
        check("to_next_valid", 32'(bus.out_valid), 32'd1);
        check("to_next_data", 32'(bus.out_data), 32'h029);
        pop_one();

        // Overflow: one more code than the FIFO holds
        for (int i = 0; i < int'(DEPTH); i++) send_frame(8'h10 + 8'(i), 1'b0);
        check("ovf_full_noovf", 32'(overflow), 32'd0);
        send_frame(8'h10 + 8'(DEPTH), 1'b0);
        check("ovf_valid", 32'(bus.out_valid), 32'd1);
        check("ovf_flag", 32'(overflow), 32'd1);
        for (int i = 0; i < int'(DEPTH); i++) begin
            check($sformatf("ovf_drain%0d", i), 32'(bus.out_data), 32'h010 + 32'(i));
            pop_one();
        end
        check("ovf_empty", 32'(bus.out_valid), 32'd0);
        clr_pulse();
        check("ovf_clr", 32'(overflow), 32'd0);

        // Randomised frames against the reference decoder
        for (int n = 0; n < 40; n++) begin
            case ($urandom_range(0, 9))
                0:       b = 8'hE0;
                1:       b = 8'hF0;
                default: b = 8'($urandom_range(0, 255));
            endcase
            bad = ($urandom_range(0, 9) == 0);
            send_frame(b, bad);
            if (bad) begin
                check("rnd_ferr", 32'(frame_err), 32'd1);
                check("rnd_bad_valid", 32'(bus.out_valid), 32'd0);
                clr_pulse();
            end else begin
                model_byte(b);
                if (mq.size() > 0) begin
                    e = mq.pop_front();
                    check("rnd_valid", 32'(bus.out_valid), 32'd1);
                    check("rnd_data", 32'(bus.out_data), 32'(e));
                    pop_one();
                end
                check("rnd_none", 32'(bus.out_valid), 32'd0);
                check("rnd_ferr0", 32'(frame_err), 32'd0);
            end
        end

        // Reset asserted mid-frame with an event queued and an error pending
        send_frame(8'h1C, 1'b0);
        send_frame(8'h33, 1'b1);
        check("mr_pre_valid", 32'(bus.out_valid), 32'd1);
        check("mr_pre_ferr", 32'(frame_err), 32'd1);
        code5a = 8'h5A;
        send_bit(1'b0);
        for (int i = 0; i < 4; i++) send_bit(code5a[i]);
        ps2_data = code5a[4];
        cyc(8);
        ps2_clk = 1'b0;
        cyc(3);
        reset = 1'b0;
        cyc(1);
        check("mr_valid", 32'(bus.out_valid), 32'd0);
        check("mr_data", 32'(bus.out_data), 32'd0);
        check("mr_ovf", 32'(overflow), 32'd0);
        check("mr_ferr", 32'(frame_err), 32'd0);
        ps2_clk = 1'b1;
        cyc(4);
        reset = 1'b1;
        m_ext = 1'b0;
        m_brk = 1'b0;
        cyc(8);
        check("mr_rel_valid", 32'(bus.out_valid), 32'd0);
        send_frame(8'h5A, 1'b0);
        check("mr_next_valid", 32'(bus.out_valid), 32'd1);
        check("mr_next_data", 32'(bus.out_data), 32'h05A);
        check("mr_next_ferr", 32'(frame_err), 32'd0);
        pop_one();

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/ps2_scancode_rx.md
PS2_SCANCODE_RX -- requirements
Module: ps2_scancode_rx

Interface
REQ-001 SHALL have parameter FIFO_DEPTH, default 8: event FIFO entries; power of 2, 2..64.
REQ-002 SHALL have parameter SYNC_STAGES, default 3: synchroniser flops on ps2_clk/ps2_data; minimum 2.
REQ-003 SHALL have parameter TIMEOUT_CYCLES, default 50000: idle-clock cycles after which a partial frame is aborted.
REQ-004 SHALL have port clk  input  1  system clock; all state on its rising edge.
REQ-005 SHALL have port reset  input  1  asynchronous, active-low reset.
REQ-006 SHALL have port ps2_clk  input  1  raw PS/2 clock, asynchronous to clk.
REQ-007 SHALL have port ps2_data  input  1  raw PS/2 data, asynchronous to clk.
REQ-008 SHALL have port out_data  output  10  head event {ext, brk, code[7:0]}.
REQ-009 SHALL have port out_valid  output  1  FIFO non-empty; out_data valid.
REQ-010 SHALL have port out_ready  input  1  consumer accepts head event.
REQ-011 SHALL have port overflow  output  1  sticky: event dropped, FIFO full.
REQ-012 SHALL have port frame_err  output  1  sticky: bad start/stop/parity or timeout.
REQ-013 SHALL have port clr_err  input  1  one-cycle pulse clearing overflow and frame_err.

Function
REQ-014 SHALL pass ps2_clk and ps2_data through SYNC_STAGES flops; sample edge = synced ps2_clk previous 1, current 0.
REQ-015 SHALL receive frame FSM states IDLE, SHIFT, CHECK: IDLE->SHIFT on a sample edge (bit 0 captured); SHIFT captures bits 1..10, LSB-first data in bits 1..8; after bit 10, CHECK for exactly one cycle, then IDLE.
REQ-016 SHALL accept a frame in CHECK iff bit0==0, bit10==1, XOR of bits 1..9 ==1; accepted byte goes to decoder that cycle.
REQ-017 SHALL discard a rejected frame and set frame_err.
REQ-018 SHALL, in SHIFT, count clk cycles since last sample edge; at TIMEOUT_CYCLES: return to IDLE, discard bits, set frame_err; counter clears on every sample edge.
REQ-019 SHALL decode with FSM D_BASE/D_EXT/D_BRK/D_EXT_BRK: 8'hE0 sets ext, 8'hF0 sets brk, no event pushed; any other byte pushes {ext,brk,byte} and returns to D_BASE.
REQ-020 SHALL treat E0 received in D_BRK or D_EXT_BRK as a code byte (pushed), and repeated F0/E0 as idempotent.
REQ-021 SHALL implement first-word-fall-through FIFO: out_valid = !empty; out_data = head; pop when out_valid & out_ready.
REQ-022 SHALL assert out_valid the cycle after CHECK of a code byte into an empty FIFO (2 cycles after the detected stop-bit edge).
REQ-023 SHALL, on push to a full FIFO without same-cycle pop, drop the event and set overflow; with same-cycle pop, accept both.
REQ-024 SHALL wrap read/write pointers modulo FIFO_DEPTH with an extra bit distinguishing full from empty.
REQ-025 SHALL hold out_data stable while out_valid & !out_ready.
REQ-026 SHALL clear overflow/frame_err on clr_err; a same-cycle set event wins.

Reset
REQ-027 SHALL, while reset==0: FIFO empty, out_valid=0, out_data=0, overflow=0, frame_err=0, frame FSM IDLE, decoder D_BASE, timeout counter 0.
REQ-028 SHALL reset synchroniser flops to 1 so release causes no spurious edge.
REQ-029 SHALL discard a frame in progress at reset assertion; no partial event survives.

Structure
REQ-030 SHALL place in shared package ps2_pkg: frame/decoder state encodings, constants E0=8'hE0, F0=8'hF0, EVENT_W=10.
REQ-031 SHALL instantiate FIFO as sub-module ps2_event_fifo (params DEPTH, WIDTH); the rest stays in ps2_scancode_rx.

Verification
REQ-032 SHALL cover: frame 8'h1C, good parity -> one event 10'h01C, out_valid 2 cycles after stop edge.
REQ-033 SHALL cover: bytes E0,F0,75 -> single event 10'h375; then 75 -> 10'h075.
REQ-034 SHALL cover: frame 8'h1C with parity inverted -> no event, frame_err=1; clr_err -> frame_err=0.
REQ-035 SHALL cover: 4 bits then ps2_clk held high TIMEOUT_CYCLES -> frame_err=1; next good frame 8'h29 -> event 10'h029.
REQ-036 SHALL cover: out_ready=0, FIFO_DEPTH+1 codes -> out_valid=1, overflow=1, drain yields first FIFO_DEPTH codes in order.
REQ-037 SHALL cover: reset low mid-frame (bit 5) -> all outputs 0; after release, next good frame decodes correctly.
